// File: rtl/arm_pkg.sv
// Shared constants and helpers for the data-processing immediate encoder.
// The rotate helper is common to the fit test and anything else that needs ROL by 2*rot.
package arm_pkg;

    localparam int IMM_W     = 8;
    localparam int ROT_W     = 4;
    localparam int ROT_STEPS = 16;

    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);
    localparam logic [ROT_W-1:0] ROT_ONE  = ROT_W'(1);

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_SCAN = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef struct packed {
        logic [ROT_W-1:0] rot;
        logic [IMM_W-1:0] imm;
    } enc_field_t;

    // Rotate left by twice the 4-bit rotation field, modulo 32.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [ROT_W-1:0] r);
        logic [63:0] dbl;
        dbl = {x, x} << {r, 1'b0};
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/imm_rot_fit.sv
// Combinational fit test: does x reduce to an 8-bit immediate when rotated left by 2*r?
// imm8 is only meaningful when fit is high.
module imm_rot_fit
    import arm_pkg::*;
(
    input  logic [31:0]      x,
    input  logic [ROT_W-1:0] r,
    output logic             fit,
    output logic [IMM_W-1:0] imm8
);

    logic [31:0] rotated;

    assign rotated = rol32(x, r);
    assign fit     = (rotated[31:IMM_W] == '0);
    assign imm8    = rotated[IMM_W-1:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative encoder: finds {rot4, imm8} with ROR(imm8, 2*rot4) == value, one rotation per cycle.
// Falls back to encoding ~value when ALLOW_INVERT is set and no direct encoding exists.
module imm_rot_encoder
    import arm_pkg::*;
#(
    parameter bit ALLOW_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [11:0] enc_field,
    output logic        enc_invert,
    output logic        enc_fail
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      val_q, val_d;
    logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic             inv_hit_q, inv_hit_d;
    enc_field_t       inv_slot_q, inv_slot_d;
    enc_field_t       enc_field_q, enc_field_d;
    logic             enc_invert_q, enc_invert_d;
    logic             enc_fail_q, enc_fail_d;

    logic             dir_fit;
    logic [IMM_W-1:0] dir_imm;
    logic             inv_fit;
    logic [IMM_W-1:0] inv_imm;

    imm_rot_fit u_fit_dir (
        .x    (val_q),
        .r    (rot_cnt_q),
        .fit  (dir_fit),
        .imm8 (dir_imm)
    );

    generate
        if (ALLOW_INVERT) begin : g_inv
            logic [31:0] val_inv;
            assign val_inv = ~val_q;
            imm_rot_fit u_fit_inv (
                .x    (val_inv),
                .r    (rot_cnt_q),
                .fit  (inv_fit),
                .imm8 (inv_imm)
            );
        end else begin : g_no_inv
            assign inv_fit = 1'b0;
            assign inv_imm = '0;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        val_d        = val_q;
        rot_cnt_d    = rot_cnt_q;
        inv_hit_d    = inv_hit_q;
        inv_slot_d   = inv_slot_q;
        enc_field_d  = enc_field_q;
        enc_invert_d = enc_invert_q;
        enc_fail_d   = enc_fail_q;

        case (state_q)
            ENC_IDLE: begin
                if (start) begin
                    state_d   = ENC_SCAN;
                    val_d     = value_in;
                    rot_cnt_d = '0;
                    inv_hit_d = 1'b0;
                end
            end
            ENC_SCAN: begin
                if (dir_fit) begin
                    state_d      = ENC_DONE;
                    enc_field_d  = '{rot: rot_cnt_q, imm: dir_imm};
                    enc_invert_d = 1'b0;
                    enc_fail_d   = 1'b0;
                end else begin
                    // Only the first inverse hit is kept so the result stays canonical.
                    if (inv_fit && !inv_hit_q) begin
                        inv_hit_d  = 1'b1;
                        inv_slot_d = '{rot: rot_cnt_q, imm: inv_imm};
                    end
                    if (rot_cnt_q == ROT_LAST) begin
                        state_d = ENC_DONE;
                        if (inv_hit_d) begin
                            enc_field_d  = inv_slot_d;
                            enc_invert_d = 1'b1;
                            enc_fail_d   = 1'b0;
                        end else begin
                            enc_field_d  = '0;
                            enc_invert_d = 1'b0;
                            enc_fail_d   = 1'b1;
                        end
                    end else begin
                        rot_cnt_d = rot_cnt_q + ROT_ONE;
                    end
                end
            end
            ENC_DONE: state_d = ENC_IDLE;
            default:  state_d = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ENC_IDLE;
            val_q        <= '0;
            rot_cnt_q    <= '0;
            inv_hit_q    <= 1'b0;
            inv_slot_q   <= '0;
            enc_field_q  <= '0;
            enc_invert_q <= 1'b0;
            enc_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            val_q        <= val_d;
            rot_cnt_q    <= rot_cnt_d;
            inv_hit_q    <= inv_hit_d;
            inv_slot_q   <= inv_slot_d;
            enc_field_q  <= enc_field_d;
            enc_invert_q <= enc_invert_d;
            enc_fail_q   <= enc_fail_d;
        end
    end

    assign ready      = (state_q == ENC_IDLE);
    assign busy       = (state_q == ENC_SCAN);
    assign done       = (state_q == ENC_DONE);
    assign enc_field  = enc_field_q;
    assign enc_invert = enc_invert_q;
    assign enc_fail   = enc_fail_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Randomized and directed bench for imm_rot_encoder, one instance per ALLOW_INVERT setting.
// Expected results come from a brute-force forward decode over every {rot, imm8}.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_ni = 1'b0;
    logic [31:0] value_in = '0;

    logic        ready, busy, done, enc_invert, enc_fail;
    logic [11:0] enc_field;
    logic        ready_ni, busy_ni, done_ni, enc_invert_ni, enc_fail_ni;
    logic [11:0] enc_field_ni;

    int tests_run = 0;
    int tests_failed = 0;
    bit use_ni = 1'b0;

    always #5 clk = ~clk;

    imm_rot_encoder #(.ALLOW_INVERT(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .value_in   (value_in),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .enc_field  (enc_field),
        .enc_invert (enc_invert),
        .enc_fail   (enc_fail)
    );

    imm_rot_encoder #(.ALLOW_INVERT(1'b0)) u_dut_ni (
        .clk        (clk),
        .rst        (rst),
        .start      (start_ni),
        .value_in   (value_in),
        .ready      (ready_ni),
        .busy       (busy_ni),
        .done       (done_ni),
        .enc_field  (enc_field_ni),
        .enc_invert (enc_invert_ni),
        .enc_fail   (enc_fail_ni)
    );

    logic        m_ready, m_busy, m_done, m_inv, m_fail;
    logic [11:0] m_field;
    assign m_ready = use_ni ? ready_ni      : ready;
    assign m_busy  = use_ni ? busy_ni       : busy;
    assign m_done  = use_ni ? done_ni       : done;
    assign m_inv   = use_ni ? enc_invert_ni : enc_invert;
    assign m_fail  = use_ni ? enc_fail_ni   : enc_fail;
    assign m_field = use_ni ? enc_field_ni  : enc_field;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Smallest rot whose decode ROR(imm8, 2*rot) reproduces v, or -1.
    function automatic int find_rot(input logic [31:0] v, output logic [7:0] imm);
        logic [63:0] d;
        imm = '0;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 256; i++) begin
                d = {24'd0, 8'(i), 24'd0, 8'(i)} >> (2 * r);
                if (d[31:0] == v) begin
                    imm = 8'(i);
                    return r;
                end
            end
        end
        return -1;
    endfunction

    task automatic model(input logic [31:0] v, input bit allow_inv,
                         output logic [11:0] f, output logic inv, output logic fl, output int lat);
        int r;
        logic [7:0] imm;
        r = find_rot(v, imm);
        f = '0; inv = 1'b0; fl = 1'b0; lat = 17;
        if (r >= 0) begin
            f = {4'(r), imm};
            lat = r + 2;
        end else begin
            if (allow_inv) r = find_rot(~v, imm);
            if (allow_inv && r >= 0) begin
                f = {4'(r), imm};
                inv = 1'b1;
            end else begin
                fl = 1'b1;
            end
        end
    endtask

    // Called #1 after a rising edge with the selected DUT idle; start is sampled at the next edge (cycle 0).
    task automatic run_search(input bit ni, input logic [31:0] v);
        logic [11:0] ef;
        logic ei, efl;
        int lat, cyc;
        use_ni = ni;
        model(v, !ni, ef, ei, efl, lat);
        value_in = v;
        if (ni) start_ni = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        start = 1'b0; start_ni = 1'b0;
        value_in = $urandom;
        check("busy_c1", 32'(m_busy), 32'd1);
        while (!m_done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("field", 32'(m_field), 32'(ef));
        check("invert", 32'(m_inv), 32'(ei));
        check("fail", 32'(m_fail), 32'(efl));
        $display("[TB] txn ai=%0d val=0x%08h field=0x%03h inv=%0d fail=%0d cyc=%0d (exp 0x%03h %0d %0d %0d)",
                 !ni, v, m_field, m_inv, m_fail, cyc, ef, ei, efl, lat);
        @(posedge clk); #1;
        check("ready_after", 32'(m_ready), 32'd1);
        check("done_pulse", 32'(m_done), 32'd0);
        check("hold_field", 32'(m_field), 32'(ef));
    endtask

    function automatic logic [31:0] rand_value();
        logic [63:0] d;
        logic [7:0] imm;
        int s;
        imm = 8'($urandom);
        s = 2 * $urandom_range(0, 15);
        d = {24'd0, imm, 24'd0, imm} >> s;
        case ($urandom_range(0, 3))
            0: return d[31:0];
            1: return ~d[31:0];
            2: return $urandom;
            default: return {24'd0, imm};
        endcase
    endfunction

    initial begin
        logic [31:0] dir_vals [7];
        int cyc;
        dir_vals = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h000003FC,
                     32'hFFFFFF00, 32'h00000101, 32'h00000000};

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_field", 32'(enc_field), 32'd0);
        check("rst_inv", 32'(enc_invert), 32'd0);
        check("rst_fail", 32'(enc_fail), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (dir_vals[i]) run_search(1'b0, dir_vals[i]);
        foreach (dir_vals[i]) run_search(1'b1, dir_vals[i]);

        // start held high through a busy search; value_in changes after capture.
        use_ni = 1'b0;
        value_in = 32'h000003FC;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        value_in = 32'h000000FF;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_lat1", 32'(cyc), 32'd17);
        check("b2b_field1", 32'(enc_field), 32'hFFF);
        @(posedge clk); #1;
        check("b2b_ready", 32'(ready), 32'd1);
        check("b2b_hold", 32'(enc_field), 32'hFFF);
        @(posedge clk); #1;
        cyc = 1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_lat2", 32'(cyc), 32'd2);
        check("b2b_field2", 32'(enc_field), 32'h0FF);
        $display("[TB] txn back-to-back second field=0x%03h cyc=%0d", enc_field, cyc);
        @(posedge clk); #1;

        // Reset in cycle 5 of a search that would end in an inverse hit.
        run_search(1'b0, 32'hFF000000);
        value_in = 32'hFFFFFF00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            check("rst_nodone", 32'(done), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_field", 32'(enc_field), 32'd0);
        check("mid_inv", 32'(enc_invert), 32'd0);
        check("mid_fail", 32'(enc_fail), 32'd0);
        $display("[TB] txn reset mid-scan ready=%0d field=0x%03h", ready, enc_field);
        run_search(1'b0, 32'h000000FF);

        for (int n = 0; n < 40; n++) run_search(1'b0, rand_value());
        for (int n = 0; n < 40; n++) run_search(1'b1, rand_value());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
